result_history: RTL and testbench
=================================

# result_history

Pipeline result-history and architectural register file for the 16-bit core. It records each issued instruction's destination register, write enable and result as the instruction moves through the six post-execute pipeline slots. It presents those slots, newest first, as the m1..m6 data/num/write inputs of the forwarding unit, and retires the oldest slot into an 8 x 16 register file. It also supplies the register-file read value that the forwarding unit selects against.

## Interface
Parameters:
- DATA_W, 16, result/register width
- REG_W, 3, register-number width (2**REG_W architectural registers)
- DEPTH, 6, number of in-flight history slots (m1..mDEPTH)
- LOAD_SLOT, 2, slot whose data is overwritten by a late load result (1..DEPTH-1)
- FLUSH_SLOTS, 2, number of youngest slots killed by a flush (0..DEPTH)

Ports (clock and reset first):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- adv_in  in  1  pipeline advances this cycle; 0 = stall, history holds
- iss_valid_in  in  1  instruction leaving execute, enters m1 on advance
- iss_write_in  in  1  that instruction writes a register
- iss_num_in  in  REG_W  its destination register
- iss_data_in  in  DATA_W  its execute result
- ld_valid_in  in  1  late load data for the entry currently in slot LOAD_SLOT
- ld_data_in  in  DATA_W  the load data
- flush_in  in  1  kill the FLUSH_SLOTS youngest entries
- rd_num_a_in, rd_num_b_in  in  REG_W  register-file read addresses
- rd_data_a_out, rd_data_b_out  out  DATA_W  register-file read data, combinational
- m_data_out  out  DEPTH*DATA_W  slot k data at bits [k*DATA_W-1 -: DATA_W], slot 1 in the LSBs
- m_num_out  out  DEPTH*REG_W  slot destination numbers, same packing
- m_write_out  out  DEPTH  bit k-1 = slot k write enable

## Operation
- Slot record is {write, num, data}; slot 1 is the youngest.
- Advance (adv_in=1):
  - Slot k+1 takes slot k for k = 1..DEPTH-1.
  - Slot 1 takes {iss_valid_in & iss_write_in, iss_num_in, iss_data_in}.
  - If slot DEPTH held write=1, regfile[num] is written with its data.
- Stall (adv_in=0): slot contents hold and there is no commit. The iss_* inputs are ignored.
- Load update: if ld_valid_in=1, ld_data_in replaces the data of the entry currently in slot LOAD_SLOT. After an advance that entry is in slot LOAD_SLOT+1; after a stall it is still in slot LOAD_SLOT. The update applies regardless of that slot's write flag.
- Flush: the next-state write flags of slots 1..FLUSH_SLOTS are forced to 0. This applies after any shift, so an instruction issued in the flush cycle is also killed. num and data are not cleared. A flush during a stall clears the current slots 1..FLUSH_SLOTS.
- Commit and flush in the same cycle: the commit still happens, because slot DEPTH is older than every flushed slot when FLUSH_SLOTS < DEPTH.
- Register 0 is an ordinary writable register.
- Register-file reads:
  - The read ports are purely combinational from the array and have no write-through.
  - A same-cycle read of a register being committed returns the old value. This is correct because the committing entry is still visible in slot DEPTH for forwarding.
- Reset: every slot is set to {0,0,0}, all registers are set to 0, and all outputs read 0.

## Timing
- m_*_out come directly from flops. An issue at edge N is visible in slot 1 after edge N, and in slot k after k advancing edges.
- A committed value is visible on rd_data_*_out in the cycle after the commit edge.
- Load data is visible on m_data_out in the cycle after ld_valid_in is sampled.
- Asserting rst_n low mid-operation clears everything immediately (asynchronous reset). In-flight commits are lost. The first advance after release fills slot 1 only.

## Structure
- Shared package `core_pkg`:
  - DATA_W and REG_W constants
  - typedef `hist_entry_t` = packed {write, num, data}
- One sub-module, `regfile_2r1w`: 2**REG_W x DATA_W array with asynchronous reset, two combinational read ports and one write port.
- The history shift, load-update and flush logic stays in `result_history`.

## Test plan
- Reset then issue r3 = 0x1234: after 1 edge, slot 1 = {1,3,0x1234}; after 6 more advances, rd_data_a_out with rd_num_a_in=3 reads 0x1234 and m_write_out = 0.
- Issue r5 = 0x0001, then stall 3 cycles, then advance: the entry stays in slot 1 through the stall, then moves to slot 2. There is no commit until 6 advancing edges in total.
- Load update: with the r2 entry in slot 2 (LOAD_SLOT), drive ld_valid_in with 0xBEEF and adv_in=1 -> slot 3 data = 0xBEEF next cycle. Repeat with adv_in=0 -> slot 2 data = 0xBEEF.
- Flush while issuing r1 = 0x0AAA with history full of writes -> next cycle m_write_out[1:0] = 0 and bits [5:2] are unchanged. The slot-6 entry still commits.
- Same-cycle commit/read: r7 = 0x5555 in slot 6 and regfile r7 = 0x0000, with adv_in=1 and rd_num_b_in=7 -> rd_data_b_out = 0x0000 that cycle and 0x5555 the next.
- Assert rst_n low mid-stream: all outputs are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants and the pipeline history record used across the 16-bit core.
package core_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef struct packed {
    logic              write;
    logic [REG_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } hist_entry_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one synchronous write port.
module regfile_2r1w #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int REG_W  = core_pkg::REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [REG_W-1:0]  wr_num,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_W-1:0]  rd_num_a,
  input  logic [REG_W-1:0]  rd_num_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b
);

  localparam int NREG = 2 ** REG_W;

  logic [DATA_W-1:0] mem [NREG];

  // NOTE: this array is deliberately reset so every register reads 0 out of reset;
  // that forces flops rather than a RAM macro, which is fine at 8 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wr_num] <= wr_data;
    end
  end

  // No write-through: the committing value is still forwardable from the last history slot.
  assign rd_data_a = mem[rd_num_a];
  assign rd_data_b = mem[rd_num_b];

endmodule

// File: rtl/result_history.sv
// Post-execute result history (m1..mDEPTH, newest first) feeding the forwarding unit,
// retiring the oldest slot into the architectural register file.
module result_history #(
  parameter int DATA_W      = core_pkg::DATA_W,
  parameter int REG_W       = core_pkg::REG_W,
  parameter int DEPTH       = 6,
  parameter int LOAD_SLOT   = 2,
  parameter int FLUSH_SLOTS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv_in,
  input  logic                    iss_valid_in,
  input  logic                    iss_write_in,
  input  logic [REG_W-1:0]        iss_num_in,
  input  logic [DATA_W-1:0]       iss_data_in,
  input  logic                    ld_valid_in,
  input  logic [DATA_W-1:0]       ld_data_in,
  input  logic                    flush_in,
  input  logic [REG_W-1:0]        rd_num_a_in,
  input  logic [REG_W-1:0]        rd_num_b_in,
  output logic [DATA_W-1:0]       rd_data_a_out,
  output logic [DATA_W-1:0]       rd_data_b_out,
  output logic [DEPTH*DATA_W-1:0] m_data_out,
  output logic [DEPTH*REG_W-1:0]  m_num_out,
  output logic [DEPTH-1:0]        m_write_out
);

  // Same layout as core_pkg::hist_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic              write;
    logic [REG_W-1:0]  num;
    logic [DATA_W-1:0] data;
  } slot_t;

  // Index 0 is slot 1 (youngest), index DEPTH-1 is the committing slot.
  slot_t hist_q [DEPTH];
  slot_t hist_d [DEPTH];
  logic  commit;

  assign commit = adv_in & hist_q[DEPTH-1].write;

  always_comb begin
    // NOTE: every slot gets a default first so no path through this block infers a latch.
    for (int k = 0; k < DEPTH; k++) hist_d[k] = hist_q[k];

    if (adv_in) begin
      for (int k = DEPTH - 1; k > 0; k--) hist_d[k] = hist_q[k-1];
      hist_d[0] = '{write: iss_valid_in & iss_write_in, num: iss_num_in, data: iss_data_in};
    end

    // The loaded entry has moved one slot older if the pipeline advanced.
    if (ld_valid_in) begin
      if (adv_in) hist_d[LOAD_SLOT].data   = ld_data_in;
      else        hist_d[LOAD_SLOT-1].data = ld_data_in;
    end

    // Applied after the shift so an instruction issued in the flush cycle dies too.
    if (flush_in) begin
      for (int k = 0; k < FLUSH_SLOTS; k++) hist_d[k].write = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all slots update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) hist_q[k] <= hist_d[k];
    end
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (commit),
    .wr_num    (hist_q[DEPTH-1].num),
    .wr_data   (hist_q[DEPTH-1].data),
    .rd_num_a  (rd_num_a_in),
    .rd_num_b  (rd_num_b_in),
    .rd_data_a (rd_data_a_out),
    .rd_data_b (rd_data_b_out)
  );

  for (genvar k = 0; k < DEPTH; k++) begin : g_out
    assign m_data_out[k*DATA_W +: DATA_W] = hist_q[k].data;
    assign m_num_out[k*REG_W +: REG_W]    = hist_q[k].num;
    assign m_write_out[k]                 = hist_q[k].write;
  end

endmodule

// File: tb/tb_result_history.sv
// Directed test of result_history: issue/commit, stall, late load, flush, read timing, async reset.
module tb_result_history;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adv, iss_valid, iss_write, ld_valid, flush;
  logic [2:0]  iss_num, rd_a, rd_b;
  logic [15:0] iss_data, ld_data;
  logic [15:0] rd_data_a, rd_data_b;
  logic [95:0] m_data;
  logic [17:0] m_num;
  logic [5:0]  m_write;

  int compared   = 0;
  int mismatched = 0;

  result_history dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .adv_in        (adv),
    .iss_valid_in  (iss_valid),
    .iss_write_in  (iss_write),
    .iss_num_in    (iss_num),
    .iss_data_in   (iss_data),
    .ld_valid_in   (ld_valid),
    .ld_data_in    (ld_data),
    .flush_in      (flush),
    .rd_num_a_in   (rd_a),
    .rd_num_b_in   (rd_b),
    .rd_data_a_out (rd_data_a),
    .rd_data_b_out (rd_data_b),
    .m_data_out    (m_data),
    .m_num_out     (m_num),
    .m_write_out   (m_write)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] slot_data(input logic [95:0] v, input int k);
    return v[k*16-1 -: 16];
  endfunction

  function automatic logic [2:0] slot_num(input logic [17:0] v, input int k);
    return v[k*3-1 -: 3];
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    adv = 0; iss_valid = 0; iss_write = 0; iss_num = 0; iss_data = 0;
    ld_valid = 0; ld_data = 0; flush = 0;
  endtask

  task automatic issue(input logic [2:0] n, input logic [15:0] d);
    adv = 1; iss_valid = 1; iss_write = 1; iss_num = n; iss_data = d;
    tick;
    idle;
  endtask

  task automatic advance_empty(input int n);
    for (int i = 0; i < n; i++) begin
      adv = 1;
      tick;
      idle;
    end
  endtask

  task automatic do_reset;
    idle;
    rst_n = 0;
    tick;
    rst_n = 1;
  endtask

  task automatic test_reset;
    do_reset;
    rd_a = 3'd5; rd_b = 3'd0;
    #1;
    compared++;
    if ({m_write, m_num, m_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_slots: got w=%h n=%h d=%h expected all 0", m_write, m_num, m_data);
    end
    compared++;
    if ({rd_data_a, rd_data_b} !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_regs: got a=%h b=%h expected 0", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_issue_commit;
    do_reset;
    issue(3'd3, 16'h1234);
    compared++;
    if (m_write !== 6'b000001 || slot_num(m_num, 1) !== 3'd3 || slot_data(m_data, 1) !== 16'h1234) begin
      mismatched++;
      $display("FAIL issue_slot1: got w=%b n=%0d d=%h expected w=000001 n=3 d=1234",
               m_write, slot_num(m_num, 1), slot_data(m_data, 1));
    end
    advance_empty(5);
    rd_a = 3'd3;
    #1;
    compared++;
    if (m_write !== 6'b100000 || rd_data_a !== 16'h0000) begin
      mismatched++;
      $display("FAIL issue_slot6: got w=%b r3=%h expected w=100000 r3=0000", m_write, rd_data_a);
    end
    advance_empty(1);
    compared++;
    if (rd_data_a !== 16'h1234 || m_write !== 6'b000000) begin
      mismatched++;
      $display("FAIL issue_commit: got r3=%h w=%b expected r3=1234 w=000000", rd_data_a, m_write);
    end
  endtask

  task automatic test_stall;
    do_reset;
    issue(3'd5, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      // Issue inputs are driven during the stall and must be ignored.
      adv = 0; iss_valid = 1; iss_write = 1; iss_num = 3'd7; iss_data = 16'hFFFF;
      tick;
      idle;
      compared++;
      if (m_write !== 6'b000001 || slot_num(m_num, 1) !== 3'd5 || slot_data(m_data, 1) !== 16'h0001) begin
        mismatched++;
        $display("FAIL stall_hold%0d: got w=%b n=%0d d=%h expected w=000001 n=5 d=0001",
                 i, m_write, slot_num(m_num, 1), slot_data(m_data, 1));
      end
    end
    advance_empty(1);
    compared++;
    if (m_write !== 6'b000010 || slot_data(m_data, 2) !== 16'h0001) begin
      mismatched++;
      $display("FAIL stall_resume: got w=%b d2=%h expected w=000010 d2=0001", m_write, slot_data(m_data, 2));
    end
    advance_empty(4);
    rd_a = 3'd5;
    #1;
    compared++;
    if (m_write !== 6'b100000 || rd_data_a !== 16'h0000) begin
      mismatched++;
      $display("FAIL stall_no_early_commit: got w=%b r5=%h expected w=100000 r5=0000", m_write, rd_data_a);
    end
    advance_empty(1);
    compared++;
    if (rd_data_a !== 16'h0001) begin
      mismatched++;
      $display("FAIL stall_commit: got r5=%h expected 0001", rd_data_a);
    end
  endtask

  task automatic test_load;
    do_reset;
    issue(3'd2, 16'h2222);
    advance_empty(1);
    adv = 1; ld_valid = 1; ld_data = 16'hBEEF;
    tick;
    idle;
    compared++;
    if (slot_data(m_data, 3) !== 16'hBEEF || slot_num(m_num, 3) !== 3'd2 || m_write !== 6'b000100) begin
      mismatched++;
      $display("FAIL load_adv: got d3=%h n3=%0d w=%b expected d3=beef n3=2 w=000100",
               slot_data(m_data, 3), slot_num(m_num, 3), m_write);
    end
    issue(3'd6, 16'h6666);
    advance_empty(1);
    adv = 0; ld_valid = 1; ld_data = 16'hCAFE;
    tick;
    idle;
    compared++;
    if (slot_data(m_data, 2) !== 16'hCAFE || slot_num(m_num, 2) !== 3'd6 || slot_data(m_data, 5) !== 16'hBEEF) begin
      mismatched++;
      $display("FAIL load_stall: got d2=%h n2=%0d d5=%h expected d2=cafe n2=6 d5=beef",
               slot_data(m_data, 2), slot_num(m_num, 2), slot_data(m_data, 5));
    end
    advance_empty(6);
    rd_a = 3'd2; rd_b = 3'd6;
    #1;
    compared++;
    if (rd_data_a !== 16'hBEEF || rd_data_b !== 16'hCAFE) begin
      mismatched++;
      $display("FAIL load_commit: got r2=%h r6=%h expected r2=beef r6=cafe", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_flush;
    do_reset;
    for (int i = 0; i < 6; i++) issue(3'(i), 16'h0100 + 16'(i));
    adv = 1; flush = 1; iss_valid = 1; iss_write = 1; iss_num = 3'd1; iss_data = 16'h0AAA;
    tick;
    idle;
    rd_a = 3'd0;
    #1;
    compared++;
    if (m_write !== 6'b111100) begin
      mismatched++;
      $display("FAIL flush_write: got %b expected 111100", m_write);
    end
    compared++;
    if (slot_num(m_num, 1) !== 3'd1 || slot_data(m_data, 1) !== 16'h0AAA || slot_data(m_data, 6) !== 16'h0101) begin
      mismatched++;
      $display("FAIL flush_keep: got n1=%0d d1=%h d6=%h expected n1=1 d1=0aaa d6=0101",
               slot_num(m_num, 1), slot_data(m_data, 1), slot_data(m_data, 6));
    end
    compared++;
    if (rd_data_a !== 16'h0100) begin
      mismatched++;
      $display("FAIL flush_commit_r0: got %h expected 0100", rd_data_a);
    end
    adv = 0; flush = 1;
    tick;
    idle;
    compared++;
    if (m_write !== 6'b111100) begin
      mismatched++;
      $display("FAIL flush_stall: got %b expected 111100", m_write);
    end
  endtask

  task automatic test_commit_read;
    do_reset;
    issue(3'd7, 16'h5555);
    advance_empty(5);
    adv = 1; rd_b = 3'd7;
    #1;
    compared++;
    if (rd_data_b !== 16'h0000 || slot_num(m_num, 6) !== 3'd7) begin
      mismatched++;
      $display("FAIL commit_read_same: got r7=%h n6=%0d expected r7=0000 n6=7", rd_data_b, slot_num(m_num, 6));
    end
    tick;
    idle;
    compared++;
    if (rd_data_b !== 16'h5555) begin
      mismatched++;
      $display("FAIL commit_read_next: got r7=%h expected 5555", rd_data_b);
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    issue(3'd3, 16'h3333);
    advance_empty(6);
    issue(3'd4, 16'h4444);
    rd_a = 3'd3;
    #1;
    compared++;
    if (rd_data_a !== 16'h3333 || m_write !== 6'b000001) begin
      mismatched++;
      $display("FAIL async_pre: got r3=%h w=%b expected r3=3333 w=000001", rd_data_a, m_write);
    end
    #1;
    rst_n = 0;
    #1;
    compared++;
    if ({m_write, m_num, m_data, rd_data_a, rd_data_b} !== '0) begin
      mismatched++;
      $display("FAIL async_clear: got w=%b d=%h r3=%h expected all 0", m_write, m_data, rd_data_a);
    end
    rst_n = 1;
    issue(3'd1, 16'h0007);
    compared++;
    if (m_write !== 6'b000001 || m_data !== 96'h0007 || rd_data_a !== 16'h0000) begin
      mismatched++;
      $display("FAIL async_refill: got w=%b d=%h r3=%h expected w=000001 d=0007 r3=0000",
               m_write, m_data, rd_data_a);
    end
  endtask

  initial begin
    idle;
    rd_a = 0; rd_b = 0;
    test_reset;
    test_issue_commit;
    test_stall;
    test_load;
    test_flush;
    test_commit_read;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
